// File: rtl/seq_mult16.sv
// -----------------------------------------------------------------------------
// seq_mult16 -- 16x16 sequential shift-add multiplier, signed or unsigned.
//
// Fixed latency: the operation is accepted on a start edge in IDLE, runs 16
// shift-add steps in RUN, applies the result sign in FIX and pulses done for
// one cycle in DONE. That is 19 cycles from one accept to the next when start
// is held high.
//
// Ports
//   clk     in   1  rising-edge clock
//   rst     in   1  asynchronous active-high reset
//   start   in   1  begin a multiply (accepted only in IDLE)
//   A       in  16  multiplicand, captured on accept
//   B       in  16  multiplier, captured on accept
//   sign    in   1  1 = two's-complement operands, 0 = unsigned
//   busy    out  1  high in RUN and FIX
//   done    out  1  one-cycle pulse, prod/ovflow valid
//   prod    out 32  product, held until the next FIX
//   ovflow  out  1  product does not fit the 16-bit result format
//
// Configuration
//   SEQ_MULT16_OVFLOW_EN  defined: ovflow detection is built.
//                         undefined: ovflow is tied to 0.
// -----------------------------------------------------------------------------
module seq_mult16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        sign,
    output logic        busy,
    output logic        done,
    output logic [31:0] prod,
    output logic        ovflow
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]  state_q,  state_d;
    logic [3:0]  cnt_q,    cnt_d;
    logic [15:0] mcand_q,  mcand_d;
    logic [15:0] mplier_q, mplier_d;
    // acc[32:16] is the running upper partial product including the carry;
    // the product's low bits enter at acc[15] as the accumulator shifts right.
    logic [32:0] acc_q,    acc_d;
    logic        res_neg_q, res_neg_d;
    logic [31:0] prod_q,   prod_d;

    logic [16:0] add_sum;
    logic [31:0] mag;

`ifdef SEQ_MULT16_OVFLOW_EN
    logic        sign_q,   sign_d;
    logic        ovflow_q, ovflow_d;
`endif

    // Upper partial product plus the multiplicand when the current multiplier
    // bit is set. acc[32] is always 0 entering a step, so 17 bits hold the sum.
    assign add_sum = acc_q[32:16] + {1'b0, (mplier_q[0] ? mcand_q : 16'h0000)};
    assign mag     = acc_q[31:0];

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        res_neg_d = res_neg_q;
        prod_d    = prod_q;
`ifdef SEQ_MULT16_OVFLOW_EN
        sign_d    = sign_q;
        ovflow_d  = ovflow_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (sign) begin
                        // Negating 0x8000 in 16 bits gives 0x8000 again, which
                        // is the correct magnitude when read as unsigned.
                        mcand_d   = A[15] ? (~A + 16'd1) : A;
                        mplier_d  = B[15] ? (~B + 16'd1) : B;
                        res_neg_d = A[15] ^ B[15];
                    end else begin
                        mcand_d   = A;
                        mplier_d  = B;
                        res_neg_d = 1'b0;
                    end
`ifdef SEQ_MULT16_OVFLOW_EN
                    sign_d    = sign;
`endif
                    acc_d     = 33'd0;
                    cnt_d     = 4'd0;
                    state_d   = ST_RUN;
                end
            end

            ST_RUN: begin
                acc_d    = {1'b0, add_sum, acc_q[15:1]};
                mplier_d = {1'b0, mplier_q[15:1]};
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = ST_FIX;
                end
            end

            ST_FIX: begin
                prod_d = res_neg_q ? (~mag + 32'd1) : mag;
`ifdef SEQ_MULT16_OVFLOW_EN
                if (sign_q) begin
                    // Fits in signed 16 bits only if bits 31..15 are a pure
                    // sign extension.
                    ovflow_d = !((prod_d[31:15] == 17'h00000) ||
                                 (prod_d[31:15] == 17'h1FFFF));
                end else begin
                    ovflow_d = (prod_d[31:16] != 16'h0000);
                end
`endif
                state_d = ST_DONE;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update
    // together from values sampled before the edge. Every register, including
    // the operand and accumulator registers, is cleared by reset so a restart
    // never sees stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            mcand_q   <= 16'd0;
            mplier_q  <= 16'd0;
            acc_q     <= 33'd0;
            res_neg_q <= 1'b0;
            prod_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            res_neg_q <= res_neg_d;
            prod_q    <= prod_d;
        end
    end

`ifdef SEQ_MULT16_OVFLOW_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q   <= 1'b0;
            ovflow_q <= 1'b0;
        end else begin
            sign_q   <= sign_d;
            ovflow_q <= ovflow_d;
        end
    end

    assign ovflow = ovflow_q;
`else
    assign ovflow = 1'b0;
`endif

    assign busy = (state_q == ST_RUN) || (state_q == ST_FIX);
    assign done = (state_q == ST_DONE);
    assign prod = prod_q;

endmodule

// File: tb/tb_seq_mult16.sv
// -----------------------------------------------------------------------------
// tb_seq_mult16 -- directed self-checking bench for seq_mult16.
// Expected products are hand-computed constants. Build with or without
// SEQ_MULT16_OVFLOW_EN; the expected ovflow follows the same macro.
// -----------------------------------------------------------------------------
module tb_seq_mult16;

`ifdef SEQ_MULT16_OVFLOW_EN
    localparam bit OV_EN = 1'b1;
`else
    localparam bit OV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        sign_in;
    logic        busy;
    logic        done;
    logic [31:0] prod;
    logic        ovflow;

    int checks = 0;
    int errors = 0;

    seq_mult16 dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .A      (a_in),
        .B      (b_in),
        .sign   (sign_in),
        .busy   (busy),
        .done   (done),
        .prod   (prod),
        .ovflow (ovflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Accept one multiply, wait for done with a bounded loop, check latency,
    // result, hold of the previous product mid-run and the single done pulse.
    // If poke is set, a second start with different operands is pulsed mid-run.
    task automatic run_mult(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic s, input logic [31:0] exp_prod, input logic exp_ov,
                            input logic [31:0] prev_prod, input bit poke);
        int n;
        int extra_done;
        @(negedge clk);
        a_in = a; b_in = b; sign_in = s; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, " busy_after_accept"}, 32'(busy), 32'd1);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 8) begin
                check({tag, " prod_held_midrun"}, prod, prev_prod);
                check({tag, " busy_midrun"}, 32'(busy), 32'd1);
            end
            if (poke && n == 5) begin
                a_in = 16'h1111; start = 1'b1;
            end
            if (poke && n == 6) begin
                start = 1'b0;
            end
            if (done) break;
        end
        check({tag, " latency"}, 32'(n), 32'd17);
        check({tag, " prod"}, prod, exp_prod);
        check({tag, " ovflow"}, 32'(ovflow), 32'(exp_ov & OV_EN));
        check({tag, " busy_in_done"}, 32'(busy), 32'd0);
        extra_done = 0;
        for (int i = 0; i < 22; i++) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
        end
        check({tag, " single_done"}, 32'(extra_done), 32'd0);
        check({tag, " prod_held_idle"}, prod, exp_prod);
    endtask

    initial begin
        int n;
        int t;
        int done_t[3];
        int nd;
        logic [31:0] exp_bb[3];
        logic        ov_bb[3];

        rst = 1'b1; start = 1'b0; a_in = 16'h0; b_in = 16'h0; sign_in = 1'b0;
        #12;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset prod", prod, 32'd0);
        check("reset ovflow", 32'(ovflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_mult("u_0123x0345", 16'h0123, 16'h0345, 1'b0, 32'h0003B76F, 1'b1, 32'h0, 1'b0);
        run_mult("s_ffffx0002", 16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE, 1'b0, 32'h0003B76F, 1'b0);
        run_mult("s_8000x8000", 16'h8000, 16'h8000, 1'b1, 32'h40000000, 1'b1, 32'hFFFFFFFE, 1'b0);
        run_mult("s_8000x0001", 16'h8000, 16'h0001, 1'b1, 32'hFFFF8000, 1'b0, 32'h40000000, 1'b0);
        run_mult("s_7fffx7fff", 16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF0001, 1'b1, 32'hFFFF8000, 1'b0);
        run_mult("u_ffffx0001", 16'hFFFF, 16'h0001, 1'b0, 32'h0000FFFF, 1'b0, 32'h3FFF0001, 1'b0);
        run_mult("u_zero",      16'h0000, 16'h1234, 1'b0, 32'h00000000, 1'b0, 32'h0000FFFF, 1'b0);
        run_mult("u_00ffx0010_poke", 16'h00FF, 16'h0010, 1'b0, 32'h00000FF0, 1'b0, 32'h0, 1'b1);

        // Reset in the middle of RUN: outputs clear without a clock edge.
        @(negedge clk);
        a_in = 16'h1234; b_in = 16'h0056; sign_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 8; i++) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_midrun busy", 32'(busy), 32'd0);
        check("rst_midrun prod", prod, 32'd0);
        check("rst_midrun done", 32'(done), 32'd0);
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        check("rst_midrun no_done", 32'(nd), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_mult("after_rst", 16'h1234, 16'h0056, 1'b0, 32'h00061D78, 1'b1, 32'h0, 1'b0);

        // Back-to-back with start held high: accepts every 19 cycles.
        exp_bb[0] = 32'h0000000F; ov_bb[0] = 1'b0;
        exp_bb[1] = 32'h00000006; ov_bb[1] = 1'b0;
        exp_bb[2] = 32'hFFFE0001; ov_bb[2] = 1'b1;
        @(negedge clk);
        a_in = 16'h0003; b_in = 16'h0005; sign_in = 1'b0; start = 1'b1;
        t = 0; nd = 0;
        while (t < 100 && nd < 3) begin
            @(posedge clk);
            #1;
            if (done) begin
                done_t[nd] = t;
                check($sformatf("b2b%0d prod", nd), prod, exp_bb[nd]);
                check($sformatf("b2b%0d ovflow", nd), 32'(ovflow), 32'(ov_bb[nd] & OV_EN));
                nd++;
                if (nd == 1) begin
                    a_in = 16'hFFFE; b_in = 16'hFFFD; sign_in = 1'b1;
                end else if (nd == 2) begin
                    a_in = 16'hFFFF; b_in = 16'hFFFF; sign_in = 1'b0;
                end else begin
                    start = 1'b0;
                end
            end
            t++;
        end
        check("b2b done_count", 32'(nd), 32'd3);
        if (nd == 3) begin
            check("b2b first_latency", 32'(done_t[0]), 32'd17);
            check("b2b period1", 32'(done_t[1] - done_t[0]), 32'd19);
            check("b2b period2", 32'(done_t[2] - done_t[1]), 32'd19);
        end
        for (int i = 0; i < 3; i++) @(posedge clk);
        #1;
        check("b2b idle_after", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
